// File: rtl/id_ex.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex
//  Description : ID/EX pipeline register of the 5-stage 32-bit MIPS pipeline.
//                Captures the decoded control bits, both register-file read
//                operands, the sign-extended immediate and the Rs/Rt/Rd
//                register numbers. It presents them to the execute stage,
//                the forwarding unit and the RegDst mux one cycle later.
//                This is a pure register stage: no stall, flush or
//                combinational path from any input to any output.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               RegWrite_in,
    input  logic               MemtoReg_in,
    input  logic               MemRead_in,
    input  logic               MemWrite_in,
    input  logic               RegDst_in,
    input  logic [ALUOP_W-1:0] ALU_Op_in,
    input  logic               ALU_Src_in,
    input  logic [DATA_W-1:0]  Read_Data_1_in,
    input  logic [DATA_W-1:0]  Read_Data_2_in,
    input  logic [DATA_W-1:0]  sign_extend_in,
    input  logic [REG_W-1:0]   IF_ID_Rs_in,
    input  logic [REG_W-1:0]   IF_ID_Rt_in,
    input  logic [REG_W-1:0]   ID_Rd_in,

    output logic               RegWrite_out,
    output logic               MemtoReg_out,
    output logic               MemRead_out,
    output logic               MemWrite_out,
    output logic               RegDst_out,
    output logic [ALUOP_W-1:0] ALU_Op_out,
    output logic               ALU_Src_out,
    output logic [DATA_W-1:0]  Read_Data_1_out,
    output logic [DATA_W-1:0]  Read_Data_2_out,
    output logic [DATA_W-1:0]  sign_extend_out,
    output logic [REG_W-1:0]   ID_EX_Rs_Forward_out,
    output logic [REG_W-1:0]   ID_EX_Rt_Forward_out,
    output logic [REG_W-1:0]   ID_EX_Rs_MUX_out,
    output logic [REG_W-1:0]   ID_EX_Rt_MUX_out
);

    // Control-field registers (WB, MEM and EX groups)
    logic               r_reg_write;
    logic               r_mem_to_reg;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_reg_dst;
    logic [ALUOP_W-1:0] r_alu_op;
    logic               r_alu_src;

    // Operand and immediate registers
    logic [DATA_W-1:0]  r_read_data_1;
    logic [DATA_W-1:0]  r_read_data_2;
    logic [DATA_W-1:0]  r_sign_extend;

    // Register-number registers. Rt is held twice on purpose: one copy feeds
    // the forwarding/hazard logic, the other feeds RegDst mux input 0, so each
    // consumer sees its own flop and neither fan-out path is shared.
    logic [REG_W-1:0]   r_rs_forward;
    logic [REG_W-1:0]   r_rt_forward;
    logic [REG_W-1:0]   r_rs_mux;
    logic [REG_W-1:0]   r_rt_mux;

    // Control bits: cleared at once on reset, loaded every rising edge otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_alu_op     <= '0;
            r_alu_src    <= 1'b0;
        end else begin
            r_reg_write  <= RegWrite_in;
            r_mem_to_reg <= MemtoReg_in;
            r_mem_read   <= MemRead_in;
            r_mem_write  <= MemWrite_in;
            r_reg_dst    <= RegDst_in;
            r_alu_op     <= ALU_Op_in;
            r_alu_src    <= ALU_Src_in;
        end
    end

    // Datapath operands: bit-exact copy of the register-file reads and immediate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data_1 <= '0;
            r_read_data_2 <= '0;
            r_sign_extend <= '0;
        end else begin
            r_read_data_1 <= Read_Data_1_in;
            r_read_data_2 <= Read_Data_2_in;
            r_sign_extend <= sign_extend_in;
        end
    end

    // Register numbers routed to the forwarding unit and the RegDst mux;
    // register 0 is carried through like any other number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_forward <= '0;
            r_rt_forward <= '0;
            r_rs_mux     <= '0;
            r_rt_mux     <= '0;
        end else begin
            r_rs_forward <= IF_ID_Rs_in;
            r_rt_forward <= IF_ID_Rt_in;
            r_rs_mux     <= IF_ID_Rt_in;
            r_rt_mux     <= ID_Rd_in;
        end
    end

    assign RegWrite_out         = r_reg_write;
    assign MemtoReg_out         = r_mem_to_reg;
    assign MemRead_out          = r_mem_read;
    assign MemWrite_out         = r_mem_write;
    assign RegDst_out           = r_reg_dst;
    assign ALU_Op_out           = r_alu_op;
    assign ALU_Src_out          = r_alu_src;
    assign Read_Data_1_out      = r_read_data_1;
    assign Read_Data_2_out      = r_read_data_2;
    assign sign_extend_out      = r_sign_extend;
    assign ID_EX_Rs_Forward_out = r_rs_forward;
    assign ID_EX_Rt_Forward_out = r_rt_forward;
    assign ID_EX_Rs_MUX_out     = r_rs_mux;
    assign ID_EX_Rt_MUX_out     = r_rt_mux;

endmodule
`default_nettype wire

// File: tb/tb_id_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex
//  Description : Self-checking bench for the id_ex pipeline register. Inputs
//                are driven on the falling edge and outputs are sampled 1 ns
//                after the rising edge. Expected outputs come from a
//                reference view: "outputs equal the input set present at the
//                last rising edge, or all zero under reset".
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mrd;
        logic        mwr;
        logic        rdst;
        logic [1:0]  aop;
        logic        asrc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] se;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } in_t;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mrd;
        logic        mwr;
        logic        rdst;
        logic [1:0]  aop;
        logic        asrc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] se;
        logic [4:0]  rs_fwd;
        logic [4:0]  rt_fwd;
        logic [4:0]  rs_mux;
        logic [4:0]  rt_mux;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, RegDst_in, ALU_Src_in;
    logic [1:0]  ALU_Op_in;
    logic [31:0] Read_Data_1_in, Read_Data_2_in, sign_extend_in;
    logic [4:0]  IF_ID_Rs_in, IF_ID_Rt_in, ID_Rd_in;
    logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegDst_out, ALU_Src_out;
    logic [1:0]  ALU_Op_out;
    logic [31:0] Read_Data_1_out, Read_Data_2_out, sign_extend_out;
    logic [4:0]  ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out, ID_EX_Rs_MUX_out, ID_EX_Rt_MUX_out;

    int n_cmp = 0;
    int n_err = 0;

    id_ex #(.DATA_W(32), .REG_W(5), .ALUOP_W(2)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .RegWrite_in          (RegWrite_in),
        .MemtoReg_in          (MemtoReg_in),
        .MemRead_in           (MemRead_in),
        .MemWrite_in          (MemWrite_in),
        .RegDst_in            (RegDst_in),
        .ALU_Op_in            (ALU_Op_in),
        .ALU_Src_in           (ALU_Src_in),
        .Read_Data_1_in       (Read_Data_1_in),
        .Read_Data_2_in       (Read_Data_2_in),
        .sign_extend_in       (sign_extend_in),
        .IF_ID_Rs_in          (IF_ID_Rs_in),
        .IF_ID_Rt_in          (IF_ID_Rt_in),
        .ID_Rd_in             (ID_Rd_in),
        .RegWrite_out         (RegWrite_out),
        .MemtoReg_out         (MemtoReg_out),
        .MemRead_out          (MemRead_out),
        .MemWrite_out         (MemWrite_out),
        .RegDst_out           (RegDst_out),
        .ALU_Op_out           (ALU_Op_out),
        .ALU_Src_out          (ALU_Src_out),
        .Read_Data_1_out      (Read_Data_1_out),
        .Read_Data_2_out      (Read_Data_2_out),
        .sign_extend_out      (sign_extend_out),
        .ID_EX_Rs_Forward_out (ID_EX_Rs_Forward_out),
        .ID_EX_Rt_Forward_out (ID_EX_Rt_Forward_out),
        .ID_EX_Rs_MUX_out     (ID_EX_Rs_MUX_out),
        .ID_EX_Rt_MUX_out     (ID_EX_Rt_MUX_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference view of the stage: what the outputs must show for a captured input set
    function automatic out_t model(input in_t i);
        out_t o;
        o.rw = i.rw;   o.m2r = i.m2r; o.mrd = i.mrd; o.mwr = i.mwr;
        o.rdst = i.rdst; o.aop = i.aop; o.asrc = i.asrc;
        o.d1 = i.d1;   o.d2 = i.d2;   o.se = i.se;
        o.rs_fwd = i.rs;   // Rs goes to the forwarding unit
        o.rt_fwd = i.rt;   // Rt goes to forwarding/hazard logic
        o.rs_mux = i.rt;   // RegDst mux input 0 is Rt
        o.rt_mux = i.rd;   // RegDst mux input 1 is Rd
        return o;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.rw = 1'($urandom); v.m2r = 1'($urandom); v.mrd = 1'($urandom);
        v.mwr = 1'($urandom); v.rdst = 1'($urandom); v.aop = 2'($urandom);
        v.asrc = 1'($urandom);
        v.d1 = $urandom; v.d2 = $urandom; v.se = $urandom;
        v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom);
        return v;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.rw = RegWrite_out; o.m2r = MemtoReg_out; o.mrd = MemRead_out;
        o.mwr = MemWrite_out; o.rdst = RegDst_out; o.aop = ALU_Op_out;
        o.asrc = ALU_Src_out;
        o.d1 = Read_Data_1_out; o.d2 = Read_Data_2_out; o.se = sign_extend_out;
        o.rs_fwd = ID_EX_Rs_Forward_out; o.rt_fwd = ID_EX_Rt_Forward_out;
        o.rs_mux = ID_EX_Rs_MUX_out;     o.rt_mux = ID_EX_Rt_MUX_out;
        return o;
    endfunction

    task automatic drive(input in_t v);
        RegWrite_in = v.rw; MemtoReg_in = v.m2r; MemRead_in = v.mrd;
        MemWrite_in = v.mwr; RegDst_in = v.rdst; ALU_Op_in = v.aop;
        ALU_Src_in = v.asrc;
        Read_Data_1_in = v.d1; Read_Data_2_in = v.d2; sign_extend_in = v.se;
        IF_ID_Rs_in = v.rs; IF_ID_Rt_in = v.rt; ID_Rd_in = v.rd;
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held low with random inputs, then asynchronous mid-cycle assertion
    task automatic test_reset();
        out_t got;
        in_t  v;
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(rand_in());
            tick();
            got = sample();
            n_cmp++;
            if (got !== '0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: got %h expected 0", c, got);
            end
        end
        // first capture on first rising edge after release
        @(negedge clk);
        rst_n = 1'b1;
        v = rand_in();
        v.d1 = 32'h1234_5678;
        drive(v);
        tick();
        got = sample();
        n_cmp++;
        if (got !== model(v)) begin
            n_err++;
            $display("FAIL first_capture: got %h expected %h", got, model(v));
        end
        // async assertion between edges: outputs clear before next rising edge
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        got = sample();
        n_cmp++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected 0", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Operand capture with directed values, then no change before the next edge
    task automatic test_operand_capture();
        in_t  v;
        in_t  w;
        out_t got;
        v = rand_in();
        v.d1 = 32'h0000_000A; v.d2 = 32'hDEAD_BEEF; v.se = 32'hFFFF_8000;
        @(negedge clk);
        drive(v);
        tick();
        got = sample();
        n_cmp++;
        if (got !== model(v)) begin
            n_err++;
            $display("FAIL operand_capture: got %h expected %h", got, model(v));
        end
        w = v;
        w.d1 = 32'h5555_AAAA;
        @(negedge clk);
        drive(w);
        #2;
        n_cmp++;
        if (Read_Data_1_out !== 32'h0000_000A) begin
            n_err++;
            $display("FAIL no_change_before_edge: got %h expected 0000000a", Read_Data_1_out);
        end
        tick();
        n_cmp++;
        if (Read_Data_1_out !== 32'h5555_AAAA) begin
            n_err++;
            $display("FAIL operand_after_edge: got %h expected 5555aaaa", Read_Data_1_out);
        end
    endtask

    // Control capture and inversion taking effect only on the next edge
    task automatic test_control();
        in_t  v;
        in_t  nv;
        out_t got;
        v = rand_in();
        v.rw = 1'b1; v.m2r = 1'b0; v.mrd = 1'b1; v.mwr = 1'b0;
        v.rdst = 1'b1; v.asrc = 1'b1; v.aop = 2'b10;
        @(negedge clk);
        drive(v);
        tick();
        got = sample();
        n_cmp++;
        if (got !== model(v)) begin
            n_err++;
            $display("FAIL control_capture: got %h expected %h", got, model(v));
        end
        nv = ~v;
        @(negedge clk);
        drive(nv);
        #2;
        got = sample();
        n_cmp++;
        if (got !== model(v)) begin
            n_err++;
            $display("FAIL control_invert_early: got %h expected %h", got, model(v));
        end
        tick();
        got = sample();
        n_cmp++;
        if (got !== model(nv)) begin
            n_err++;
            $display("FAIL control_invert: got %h expected %h", got, model(nv));
        end
    endtask

    // Register-number routing with directed and boundary values
    task automatic test_routing();
        logic [4:0] rs_t [3] = '{5'd3, 5'd0, 5'd31};
        logic [4:0] rt_t [3] = '{5'd7, 5'd31, 5'd0};
        logic [4:0] rd_t [3] = '{5'd31, 5'd0, 5'd17};
        in_t  v;
        out_t got;
        for (int k = 0; k < 3; k++) begin
            v = rand_in();
            v.rs = rs_t[k]; v.rt = rt_t[k]; v.rd = rd_t[k];
            @(negedge clk);
            drive(v);
            tick();
            got = sample();
            n_cmp++;
            if ({got.rs_fwd, got.rt_fwd, got.rs_mux, got.rt_mux} !== {v.rs, v.rt, v.rt, v.rd}) begin
                n_err++;
                $display("FAIL routing%0d: got %h expected %h", k,
                         {got.rs_fwd, got.rt_fwd, got.rs_mux, got.rt_mux}, {v.rs, v.rt, v.rt, v.rd});
            end
        end
    endtask

    // Inputs wiggle several times mid-cycle; outputs hold until the edge
    task automatic test_hold();
        in_t  held;
        in_t  v;
        out_t got;
        held = rand_in();
        @(negedge clk);
        drive(held);
        tick();
        v = held;
        for (int k = 0; k < 3; k++) begin
            #2;
            v = rand_in();
            drive(v);
            got = sample();
            n_cmp++;
            if (got !== model(held)) begin
                n_err++;
                $display("FAIL hold%0d: got %h expected %h", k, got, model(held));
            end
        end
        tick();
        got = sample();
        n_cmp++;
        if (got !== model(v)) begin
            n_err++;
            $display("FAIL hold_release: got %h expected %h", got, model(v));
        end
    endtask

    // Consecutive input sets appear one cycle later, in order, none dropped
    task automatic test_back_to_back(input int n, input string tag);
        in_t  q[$];
        in_t  exp_in;
        out_t got;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            q.push_back(rand_in());
            drive(q[$]);
            tick();
            exp_in = q.pop_front();
            got = sample();
            n_cmp++;
            if (got !== model(exp_in)) begin
                n_err++;
                $display("FAIL %s%0d: got %h expected %h", tag, k, got, model(exp_in));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive('0);
        test_reset();
        test_operand_capture();
        test_control();
        test_routing();
        test_hold();
        test_back_to_back(3, "back_to_back");
        test_reset();
        test_back_to_back(200, "random_stream");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
